// File: rtl/gpio_in_pkg.sv
// rtl/gpio_in_pkg.sv - register offsets and bus widths for the GPIO input capture block
package gpio_in_pkg;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] GPIO_IN_DATA    = 3'd0;
  localparam logic [ADDR_W-1:0] GPIO_IN_CAPTURE = 3'd1;
  localparam logic [ADDR_W-1:0] GPIO_IN_MASK    = 3'd2;
  localparam logic [ADDR_W-1:0] GPIO_IN_RISE_EN = 3'd3;
  localparam logic [ADDR_W-1:0] GPIO_IN_FALL_EN = 3'd4;
  localparam logic [ADDR_W-1:0] GPIO_IN_RAW     = 3'd5;
endpackage

// File: rtl/gpio_debounce_cell.sv
// rtl/gpio_debounce_cell.sv - one input bit: 2-FF sync, optional debounce, edge detect
// GPIO_IN_DEBOUNCE_EN selects the counter-based debounce; otherwise stable follows the sync output.
module gpio_debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 250,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic sync_out,
  output logic stable_out,
  output logic rise,
  output logic fall
);
  logic s1;
  logic s2;
  logic stable;
  logic stable_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      s1       <= pin;
      s2       <= s1;
      stable_q <= stable;
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt;

  // Any return to the accepted level restarts the count, so glitches never accumulate.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (s2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 1'b0;
    end else begin
      stable <= s2;
    end
  end
`endif

  assign sync_out   = s2;
  assign stable_out = stable;
  assign rise       = stable & ~stable_q;
  assign fall       = ~stable & stable_q;
endmodule

// File: rtl/gpio_in_capture.sv
// rtl/gpio_in_capture.sv - GPIO input bank: debounced levels, W1C edge capture, irq, Avalon-MM slave
// Build option GPIO_IN_DEBOUNCE_EN enables per-bit debounce counters.
module gpio_in_capture
  import gpio_in_pkg::*;
#(
  parameter  int WIDTH           = 32,
  parameter  int DEBOUNCE_CYCLES = 250,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  pins_in,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              irq
);
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] cap_clr;
  logic [DATA_W-1:0] rd_mux;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_cell (
      .clk       (clk),
      .reset     (reset),
      .pin       (pins_in[i]),
      .sync_out  (raw[i]),
      .stable_out(stable[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

  assign wd      = writedata[WIDTH-1:0];
  assign cap_set = (rise & rise_en) | (fall & fall_en);
  assign cap_clr = (write && address == GPIO_IN_CAPTURE) ? wd : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      GPIO_IN_DATA:    rd_mux = DATA_W'(stable);
      GPIO_IN_CAPTURE: rd_mux = DATA_W'(capture);
      GPIO_IN_MASK:    rd_mux = DATA_W'(mask);
      GPIO_IN_RISE_EN: rd_mux = DATA_W'(rise_en);
      GPIO_IN_FALL_EN: rd_mux = DATA_W'(fall_en);
      GPIO_IN_RAW:     rd_mux = DATA_W'(raw);
      default:         rd_mux = '0;
    endcase
  end

  // A new edge in the same cycle as its W1C keeps the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      capture  <= '0;
      mask     <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      capture <= (capture & ~cap_clr) | cap_set;
      irq     <= |(capture & mask);
      if (write && address == GPIO_IN_MASK)    mask    <= wd;
      if (write && address == GPIO_IN_RISE_EN) rise_en <= wd;
      if (write && address == GPIO_IN_FALL_EN) fall_en <= wd;
      if (read) readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_gpio_in_capture.sv
// tb/tb_gpio_in_capture.sv - directed self-checking bench for gpio_in_capture (32-bit and 8-bit instances)
module tb_gpio_in_capture;
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int LAT = 2 + 250;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pins_in = '0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;

  logic [7:0]  pins8 = '0;
  logic [2:0]  address8 = '0;
  logic        read8 = 1'b0;
  logic        write8 = 1'b0;
  logic [31:0] writedata8 = '0;
  logic [31:0] readdata8;
  logic        irq8;

  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] rv;

  always #5 clk = ~clk;

  gpio_in_capture #(.WIDTH(32), .DEBOUNCE_CYCLES(250)) dut (
    .clk(clk), .reset(reset), .pins_in(pins_in), .address(address), .read(read),
    .write(write), .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  gpio_in_capture #(.WIDTH(8), .DEBOUNCE_CYCLES(250)) dut8 (
    .clk(clk), .reset(reset), .pins_in(pins8), .address(address8), .read(read8),
    .write(write8), .writedata(writedata8), .readdata(readdata8), .irq(irq8)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick(1);
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    tick(1);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tick(3);
    reset = 1'b0;

    // reset state of every address
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), rv);
      check($sformatf("reset_addr%0d", a), rv, 32'h0);
    end
    check("reset_irq", {31'b0, irq}, 32'h0);

    // all pins high with RISE_EN clear: levels follow, nothing captured
    pins_in = 32'hFFFF_FFFF;
    tick(LAT + 3);
    rd(1, rv); check("all_high_capture", rv, 32'h0);
    rd(0, rv); check("all_high_data", rv, 32'hFFFF_FFFF);
    rd(5, rv); check("all_high_raw", rv, 32'hFFFF_FFFF);
    pins_in = 32'h0;
    tick(LAT + 3);
    rd(0, rv); check("all_low_data", rv, 32'h0);
    rd(1, rv); check("all_low_capture", rv, 32'h0);

    // bit 0 rise: exact irq latency, then W1C
    wr(3, 32'h1);
    wr(2, 32'h1);
    pins_in[0] = 1'b1;
    tick(LAT + 1);
    check("irq_before", {31'b0, irq}, 32'h0);
    tick(1);
    check("irq_rise", {31'b0, irq}, 32'h1);
    rd(0, rv); check("rise_data", rv, 32'h1);
    rd(1, rv); check("rise_capture", rv, 32'h1);
    wr(1, 32'h1);
    check("irq_hold_after_w1c", {31'b0, irq}, 32'h1);
    tick(1);
    check("irq_cleared", {31'b0, irq}, 32'h0);
    rd(1, rv); check("capture_cleared", rv, 32'h0);

    // writes to RO / unmapped addresses ignored
    wr(0, 32'hFFFF_FFFF);
    rd(0, rv); check("data_ro", rv, 32'h1);
    wr(6, 32'hFFFF_FFFF);
    rd(6, rv); check("addr6_zero", rv, 32'h0);

    // read and write same address: read returns pre-write value
    address = 3'd2; writedata = 32'h0; read = 1'b1; write = 1'b1;
    tick(1);
    read = 1'b0; write = 1'b0;
    check("rw_same_pre", readdata, 32'h1);
    rd(2, rv); check("rw_same_post", rv, 32'h0);
    check("readdata_hold", readdata, 32'h0);

    wr(3, 32'h9);

`ifdef GPIO_IN_DEBOUNCE_EN
    // 249-cycle glitch on bit 3 never accepted
    pins_in[3] = 1'b1;
    tick(100);
    rd(5, rv); check("glitch_raw", rv, 32'h9);
    tick(148);
    pins_in[3] = 1'b0;
    tick(LAT + 3);
    rd(0, rv); check("glitch_data", rv, 32'h1);
    rd(1, rv); check("glitch_capture", rv, 32'h0);
`endif

    // fall on bit 5 in the same cycle as its W1C: set wins
    wr(4, 32'h20);
    pins_in[5] = 1'b1;
    tick(LAT + 3);
    rd(1, rv); check("bit5_rise_not_enabled", rv, 32'h0);
    pins_in[5] = 1'b0;
    tick(LAT);
    address = 3'd1; writedata = 32'h20; write = 1'b1;
    tick(1);
    write = 1'b0;
    rd(1, rv); check("set_wins_w1c", rv, 32'h20);
    rd(0, rv); check("bit5_low_data", rv, 32'h1);
    wr(1, 32'h20);
    rd(1, rv); check("w1c_bit5", rv, 32'h0);

    // one-cycle pulse on bit 1
    wr(3, 32'h2);
    pins_in[1] = 1'b1;
    tick(1);
    pins_in[1] = 1'b0;
`ifdef GPIO_IN_DEBOUNCE_EN
    tick(LAT + 3);
    rd(1, rv); check("pulse_filtered", rv, 32'h0);
`else
    tick(3);
    rd(1, rv); check("pulse_captured", rv, 32'h2);
`endif

    // 8-bit instance: upper bits read 0
    address8 = 3'd2; writedata8 = 32'hFFFF_FFFF; write8 = 1'b1;
    tick(1);
    write8 = 1'b0; read8 = 1'b1;
    tick(1);
    read8 = 1'b0;
    check("w8_mask", readdata8, 32'h0000_00FF);
    address8 = 3'd7; write8 = 1'b1;
    tick(1);
    write8 = 1'b0; read8 = 1'b1;
    tick(1);
    read8 = 1'b0;
    check("w8_addr7", readdata8, 32'h0);
    check("w8_irq", {31'b0, irq8}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
